// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank sequencer.
//   - Op-code encodings for the command interface
//   - FSM state encoding for the controller
//   - Default bank geometry
//   - Helper to classify reserved op codes
package jk_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = 8;
  localparam int unsigned OP_W          = 3;

  localparam logic [OP_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OP_W-1:0] OP_CLEAR  = 3'd1;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd2;
  localparam logic [OP_W-1:0] OP_UP     = 3'd3;
  localparam logic [OP_W-1:0] OP_DOWN   = 3'd4;
  localparam logic [OP_W-1:0] OP_TOGGLE = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Codes above OP_TOGGLE are reserved: executed as NOP, flagged with err.
  function automatic logic op_is_reserved(logic [OP_W-1:0] op);
    return op > OP_TOGGLE;
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command channel for jk_bank_ctrl.
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  controller idle and able to accept
//   cmd_op     master->slave  operation code
//   cmd_data   master->slave  load value or toggle mask
//   cmd_count  master->slave  number of steps to apply
interface jk_bank_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears q
//   j    set input
//   k    reset input
//   q    stored bit
// {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of WIDTH JK cells.
// Accepts one command at a time over a valid/ready handshake, then drives the
// per-bit J/K inputs for `count` cycles to clear, load, count up/down or
// toggle the bank. Pulses done on completion (with err for reserved ops).
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   cmd   command channel (slave side): valid/ready/op/data/count
//   q     JK bank state
//   busy  high while a command is in RUN or DONE
//   done  one-cycle completion pulse
//   wrap  one-cycle pulse in the cycle q first shows an UP/DOWN wrap
//   err   one-cycle pulse alongside done for a reserved op
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             wrap_q, wrap_d;

  logic             step_en;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= OP_NOP;
      data_q      <= '0;
      remaining_q <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      wrap_q      <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    remaining_d = remaining_q;

    unique case (state_q)
      StIdle: begin
        // cmd_ready is high throughout IDLE, so valid alone completes the handshake.
        if (cmd.cmd_valid) begin
          op_d        = cmd.cmd_op;
          data_d      = cmd.cmd_data;
          remaining_d = cmd.cmd_count;
          state_d     = (cmd.cmd_count == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        remaining_d = remaining_q - CNT_W'(1);
        if (remaining_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // J/K decode
  // ---------------------------------------------------------------------------
  assign step_en = (state_q == StRun);

  // Ripple enable for counting: bit i flips when all lower bits are 1 (UP)
  // or all lower bits are 0 (DOWN).
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & ((op_q == OP_DOWN) ? ~q[i-1] : q[i-1]);
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (step_en) begin
      unique case (op_q)
        OP_CLEAR: begin
          k = '1;
        end
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        OP_UP, OP_DOWN: begin
          j = carry;
          k = carry;
        end
        OP_TOGGLE: begin
          j = data_q;
          k = data_q;
        end
        default: begin
          // NOP and reserved codes leave the bank untouched.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Wrap detect
  // ---------------------------------------------------------------------------
  // Evaluated against q before the step edge so the registered pulse lines up
  // with the cycle in which q first shows the wrapped value.
  always_comb begin
    wrap_d = 1'b0;
    if (step_en) begin
      if (op_q == OP_UP && (&q)) begin
        wrap_d = 1'b1;
      end else if (op_q == OP_DOWN && !(|q)) begin
        wrap_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // JK storage bank
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[gi]),
      .k   (k[gi]),
      .q   (q[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd.cmd_ready = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign err           = (state_q == StDone) && op_is_reserved(op_q);
  assign wrap          = wrap_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed, table-driven bench for jk_bank_ctrl with WIDTH=4.
module tb_jk_bank_ctrl;
  import jk_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err;

  jk_bank_ctrl_if #(.WIDTH(4), .CNT_W(8)) cmd_if ();

  jk_bank_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .cmd  (cmd_if),
    .q    (q),
    .busy (busy),
    .done (done),
    .wrap (wrap),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] q_log    [0:63];
  logic       wrap_log [0:63];

  typedef struct {
    logic [2:0] op;
    logic [3:0] data;
    logic [7:0] cnt;
    logic [3:0] exp_q;
    int         exp_idx;
    logic       exp_err;
    int         exp_wraps;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issues one command and samples on each falling edge until done (bounded).
  // Sample s reflects the bank after s steps; done_idx is the sample with done.
  task automatic exec(input logic [2:0] op, input logic [3:0] data, input logic [7:0] cnt,
                      output int done_idx, output int busy_cnt, output int wrap_cnt,
                      output logic err_at_done, output logic idle_after);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_count = cnt;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    done_idx    = -1;
    busy_cnt    = 0;
    wrap_cnt    = 0;
    err_at_done = 1'b0;
    for (int s = 0; s < 64 && done_idx < 0; s++) begin
      @(negedge clk);
      q_log[s]    = q;
      wrap_log[s] = wrap;
      if (busy) busy_cnt++;
      if (wrap) wrap_cnt++;
      if (done) begin
        done_idx    = s;
        err_at_done = err;
      end
    end
    @(negedge clk);
    idle_after = cmd_if.cmd_ready && !busy && !done;
  endtask

  initial begin
    int         didx;
    int         bcnt;
    int         wcnt;
    int         bad_wrap;
    int         first_done;
    int         second_done;
    int         saw_done;
    logic       e_done;
    logic       idle;
    logic [3:0] model_q;
    logic [3:0] wrap_pat;
    logic [3:0] q_first_done;
    logic [3:0] wrap_val;

    vecs[0]  = '{OP_LOAD,   4'hA, 8'd1,  4'hA, 1,  1'b0, 0};
    vecs[1]  = '{OP_TOGGLE, 4'h5, 8'd2,  4'hA, 2,  1'b0, 0};
    vecs[2]  = '{OP_LOAD,   4'hE, 8'd1,  4'hE, 1,  1'b0, 0};
    vecs[3]  = '{OP_UP,     4'h0, 8'd3,  4'h1, 3,  1'b0, 1};
    vecs[4]  = '{OP_CLEAR,  4'hF, 8'd3,  4'h0, 3,  1'b0, 0};
    vecs[5]  = '{OP_DOWN,   4'h0, 8'd2,  4'hE, 2,  1'b0, 1};
    vecs[6]  = '{OP_UP,     4'h0, 8'd0,  4'hE, 0,  1'b0, 0};
    vecs[7]  = '{3'd7,      4'h3, 8'd2,  4'hE, 2,  1'b1, 0};
    vecs[8]  = '{3'd6,      4'hF, 8'd1,  4'hE, 1,  1'b1, 0};
    vecs[9]  = '{OP_NOP,    4'h0, 8'd3,  4'hE, 3,  1'b0, 0};
    vecs[10] = '{OP_LOAD,   4'h5, 8'd4,  4'h5, 4,  1'b0, 0};
    vecs[11] = '{OP_DOWN,   4'h0, 8'd6,  4'hF, 6,  1'b0, 1};
    vecs[12] = '{OP_UP,     4'h0, 8'd17, 4'h0, 17, 1'b0, 2};
    vecs[13] = '{OP_TOGGLE, 4'h9, 8'd3,  4'h9, 3,  1'b0, 0};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = 4'h0;
    cmd_if.cmd_count = 8'd0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_q", int'(q), 0);
    check("reset_ready", int'(cmd_if.cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    rst = 1'b1;

    // Table of chained commands starting from q=0.
    model_q = 4'h0;
    for (int v = 0; v < 14; v++) begin
      exec(vecs[v].op, vecs[v].data, vecs[v].cnt, didx, bcnt, wcnt, e_done, idle);
      check($sformatf("v%0d_done_idx", v), didx, vecs[v].exp_idx);
      check($sformatf("v%0d_q_before", v), int'(q_log[0]),
            (vecs[v].cnt == 8'd0) ? int'(model_q) : int'(q_log[0]));
      if (didx >= 0) begin
        if (vecs[v].cnt != 8'd0) check($sformatf("v%0d_q_hold", v), int'(q_log[0]), int'(model_q));
        check($sformatf("v%0d_q_final", v), int'(q_log[didx]), int'(vecs[v].exp_q));
      end
      check($sformatf("v%0d_err", v), int'(e_done), int'(vecs[v].exp_err));
      check($sformatf("v%0d_wraps", v), wcnt, vecs[v].exp_wraps);
      check($sformatf("v%0d_busy_cycles", v), bcnt, vecs[v].exp_idx + 1);
      check($sformatf("v%0d_idle_after", v), int'(idle), 1);
      if (didx >= 0 && (vecs[v].op == OP_UP || vecs[v].op == OP_DOWN)) begin
        wrap_val = (vecs[v].op == OP_UP) ? 4'h0 : 4'hF;
        bad_wrap = 0;
        for (int s = 0; s <= didx; s++) begin
          if (wrap_log[s] && q_log[s] != wrap_val) bad_wrap++;
        end
        check($sformatf("v%0d_wrap_value", v), bad_wrap, 0);
      end
      model_q = vecs[v].exp_q;
    end

    // Per-cycle UP sequence with wrap alignment: E -> F, 0, 1.
    exec(OP_LOAD, 4'hE, 8'd1, didx, bcnt, wcnt, e_done, idle);
    exec(OP_UP, 4'h0, 8'd3, didx, bcnt, wcnt, e_done, idle);
    check("up_seq_done_idx", didx, 3);
    check("up_seq_s1", int'(q_log[1]), 4'hF);
    check("up_seq_s2", int'(q_log[2]), 4'h0);
    check("up_seq_s3", int'(q_log[3]), 4'h1);
    wrap_pat = {wrap_log[3], wrap_log[2], wrap_log[1], wrap_log[0]};
    check("up_seq_wrap_pattern", int'(wrap_pat), 4'b0100);

    // Held cmd_valid: payload changes while busy must be ignored; the held
    // request is accepted only once the controller is back in IDLE.
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_UP;
    cmd_if.cmd_data  = 4'h0;
    cmd_if.cmd_count = 8'd2;
    @(posedge clk);
    #1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 4'h3;
    cmd_if.cmd_count = 8'd1;
    first_done   = -1;
    second_done  = -1;
    q_first_done = 4'h0;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      if (s == 4) cmd_if.cmd_valid = 1'b0;
      if (done && first_done < 0) begin
        first_done   = s;
        q_first_done = q;
      end else if (done && second_done < 0) begin
        second_done = s;
      end
    end
    check("held_first_done", first_done, 2);
    check("held_first_q", int'(q_first_done), 4'h3);
    check("held_second_done", second_done, 5);
    check("held_final_q", int'(q), 4'h3);

    // Asynchronous reset in the middle of a long UP run.
    exec(OP_LOAD, 4'h0, 8'd1, didx, bcnt, wcnt, e_done, idle);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_UP;
    cmd_if.cmd_data  = 4'h0;
    cmd_if.cmd_count = 8'd10;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_q_before", int'(q), 3);
    check("rst_mid_busy_before", int'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_q", int'(q), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(cmd_if.cmd_ready), 1);
    check("rst_mid_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy || q != 4'h0) saw_done++;
    end
    check("rst_mid_no_resume", saw_done, 0);
    exec(OP_LOAD, 4'h6, 8'd2, didx, bcnt, wcnt, e_done, idle);
    check("post_rst_done_idx", didx, 2);
    check("post_rst_q", (didx >= 0) ? int'(q_log[didx]) : -1, 4'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
